// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the 16x8 memory sequencer: default widths,
//   the access FSM state encoding and the requester port indices.
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        ACK  = 2'b11
    } state_t;

    localparam logic P_CPU  = 1'b0;
    localparam logic P_LOAD = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin pick.
//   req0/req1   : request lines
//   last_grant  : port granted most recently (held by the caller)
//   gnt_valid   : at least one request present
//   gnt_idx     : chosen port; on a tie, the port that did not win last
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_idx
);

    always_comb begin
        gnt_valid = req0 | req1;
        gnt_idx   = P_CPU;
        if (req0 && req1) begin
            gnt_idx = ~last_grant;
        end else if (req1) begin
            gnt_idx = P_LOAD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the 16x8 program/data memory (MAR + RAM) between the CPU path
//   (port 0) and the program loader (port 1). Each req/ack access is run as
//   IDLE -> ADDR (load MAR) -> DATA (read or write RAM) -> ACK -> IDLE.
//
//   clk, rst           : clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN : requester N access; req held until ackN
//   ackN               : one-cycle completion pulse for port N
//   rdata              : read data, held until the next read completes
//   mar_load, mem_bus, ram_we : memory-side control and bus
//   mem_out            : combinational ram[MAR] from the memory
//   busy               : FSM not in IDLE
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mar_load,
    output logic [DATA_W-1:0] mem_bus,
    output logic              ram_we,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              gnt_valid;
    logic              gnt_idx;

    rr_arb2 u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = ADDR;
            ADDR:    state_nxt = DATA;
            DATA:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_grant doubles as the owner of the access in flight, so the ack
    // decode below needs no separate granted-port register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= P_LOAD;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            rdata      <= '0;
        end else begin
            if (state == IDLE && gnt_valid) begin
                last_grant <= gnt_idx;
                if (gnt_idx == P_LOAD) begin
                    addr_q  <= addr1;
                    wdata_q <= wdata1;
                    we_q    <= we1;
                end else begin
                    addr_q  <= addr0;
                    wdata_q <= wdata0;
                    we_q    <= we0;
                end
            end
            if (state == DATA && !we_q) begin
                rdata <= mem_out;
            end
        end
    end

    // Memory-side outputs depend only on state and latched registers; with
    // state cleared asynchronously, ram_we falls the moment rst goes low.
    always_comb begin
        mar_load = 1'b0;
        ram_we   = 1'b0;
        mem_bus  = '0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            ADDR: begin
                mar_load = 1'b1;
                mem_bus  = DATA_W'(addr_q);
            end
            DATA: begin
                if (we_q) begin
                    ram_we  = 1'b1;
                    mem_bus = wdata_q;
                end
            end
            ACK: begin
                ack0 = (last_grant == P_CPU);
                ack1 = (last_grant == P_LOAD);
            end
            default: ;
        endcase
    end

endmodule
